// File: rtl/apple_spawner_pkg.sv
// Shared constants, state encoding and payload types for the apple spawner.
package apple_spawner_pkg;

  localparam int unsigned XSCREEN = 160;
  localparam int unsigned YSCREEN = 120;
  localparam int unsigned DIM     = 10;
  localparam int unsigned MAX_SEG = 4;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned PX_W  = 12;
  localparam int unsigned LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [X_W-1:0]    APPLE_X0     = 8'd30;
  localparam logic [Y_W-1:0]    APPLE_Y0     = 7'd30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PICK   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {1'b0, v[LFSR_W-1:1]} ^ (v[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/apple_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR with a loadable seed; a zero seed is remapped.
module lfsr16
  import apple_spawner_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      // All-zero would lock the register up, so substitute the default seed.
      q <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (enable) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/apple_spawner.sv
// Picks a random free grid cell for the apple, avoiding off-screen cells and snake segments.
module apple_spawner
  import apple_spawner_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed,
  input  logic [X_W*MAX_SEG-1:0]   seg_x,
  input  logic [Y_W*MAX_SEG-1:0]   seg_y,
  input  logic [CNT_W-1:0]         seg_count,
  output logic [X_W-1:0]           apple_x,
  output logic [Y_W-1:0]           apple_y,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  cell_t             cand, cand_d;
  cell_t             apple, apple_d;
  logic              valid_d, busy_d, done_d;
  logic [LFSR_W-1:0] lfsr;

  lfsr16 #(.RESET_VAL(SEED)) u_lfsr (
    .clk    (CLOCK_50),
    .rst    (reset),
    .enable (1'b1),
    .load   (seed_load),
    .seed   (seed),
    .q      (lfsr)
  );

  // Candidate cell from the low LFSR nibbles, scaled to pixels.
  logic [PX_W-1:0] col_px, row_px;
  logic            on_screen;
  assign col_px    = PX_W'(lfsr[3:0]) * PX_W'(DIM);
  assign row_px    = PX_W'(lfsr[7:4]) * PX_W'(DIM);
  assign on_screen = (col_px <= PX_W'(XSCREEN - DIM)) && (row_px <= PX_W'(YSCREEN - DIM));

  // Segment count clamped to the number of segment slots.
  logic [CNT_W-1:0] eff_count;
  logic             seg_hit, last_seg;
  assign eff_count = (seg_count > CNT_W'(MAX_SEG)) ? CNT_W'(MAX_SEG) : seg_count;
  assign seg_hit   = (eff_count != '0)
                  && (seg_x[32'(idx)*X_W +: X_W] == cand.x)
                  && (seg_y[32'(idx)*Y_W +: Y_W] == cand.y);
  assign last_seg  = (eff_count == '0) || (CNT_W'(idx) == eff_count - CNT_W'(1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cand  <= '0;
      apple <= '{x: APPLE_X0, y: APPLE_Y0};
      valid <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cand  <= cand_d;
      apple <= apple_d;
      valid <= valid_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cand_d  = cand;
    apple_d = apple;
    valid_d = valid;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = PICK;
          valid_d = 1'b0;
        end
      end
      PICK: begin
        if (on_screen) begin
          cand_d  = '{x: X_W'(col_px), y: Y_W'(row_px)};
          idx_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (seg_hit) begin
          state_d = PICK;
        end else if (last_seg) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      COMMIT: begin
        apple_d = cand;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign apple_x = apple.x;
  assign apple_y = apple.y;

endmodule

// File: tb/tb_apple_spawner.sv
// Directed and randomized checks of the apple spawner against hand-computed LFSR walks.
module tb_apple_spawner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        seed_load;
  logic [15:0] seed;
  logic [31:0] seg_x;
  logic [27:0] seg_y;
  logic [2:0]  seg_count;
  logic [7:0]  apple_x;
  logic [6:0]  apple_y;
  logic        valid;
  logic        busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;

  apple_spawner dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .seg_count (seg_count),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Seed and start in the same cycle, then check busy, latency and result.
  task automatic run_spawn(input string tag, input logic [15:0] s, input int lat,
                           input logic [7:0] ex, input logic [6:0] ey);
    seed_load = 1'b1;
    seed      = s;
    start     = 1'b1;
    tick(1);
    seed_load = 1'b0;
    start     = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_valid_lo"}, 32'(valid), 32'd0);
    tick(lat - 2);
    chk({tag, "_early_done"}, 32'(done), 32'd0);
    tick(1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_x"}, 32'(apple_x), 32'(ex));
    chk({tag, "_y"}, 32'(apple_y), 32'(ey));
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    tick(1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dones;
    reset     = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    seg_x     = '0;
    seg_y     = '0;
    seg_count = '0;
    #25;
    chk("rst_x", 32'(apple_x), 32'd30);
    chk("rst_y", 32'(apple_y), 32'd30);
    chk("rst_valid", 32'(valid), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    dones = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (done || busy) dones++;
    end
    chk("hold_activity", 32'(dones), 32'd0);
    chk("hold_x", 32'(apple_x), 32'd30);
    chk("hold_y", 32'(apple_y), 32'd30);
    chk("hold_valid", 32'(valid), 32'd1);

    // 0x0035: col 5 row 3 accepted immediately.
    seg_count = 3'd0;
    run_spawn("s35", 16'h0035, 4, 8'd50, 7'd30);

    // Segment on (50,30) forces a repick at 0x5A0D -> col 13 row 0.
    seg_count  = 3'd1;
    seg_x[7:0] = 8'd50;
    seg_y[6:0] = 7'd30;
    run_spawn("hit", 16'h0035, 6, 8'd130, 7'd0);

    // 0x00C5: row 12 rejected, then 0xB462 -> col 2 row 6.
    seg_count = 3'd0;
    run_spawn("c5", 16'h00C5, 5, 8'd20, 7'd60);
    chk("c5_yrange", 32'(apple_y <= 7'd110), 32'd1);

    // Zero seed maps to 0xACE1.
    seed_load = 1'b1;
    seed      = 16'h0000;
    tick(1);
    seed_load = 1'b0;
    chk("zero_seed_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
    // 0xACE1: row 14 rejected, then 0xE270 -> col 0 row 7.
    run_spawn("zero", 16'h0000, 5, 8'd0, 7'd70);

    // Start held during busy must not queue another spawn.
    seed_load = 1'b1;
    seed      = 16'h0035;
    start     = 1'b1;
    tick(1);
    seed_load = 1'b0;
    dones = 0;
    tick(1);
    if (done) dones++;
    tick(1);
    if (done) dones++;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (done) dones++;
    end
    chk("busy_start_dones", 32'(dones), 32'd1);
    chk("busy_start_x", 32'(apple_x), 32'd50);

    // Reset while walking four non-matching segments.
    seg_count = 3'd4;
    for (int i = 0; i < 4; i++) begin
      seg_x[i*8 +: 8] = 8'd150;
      seg_y[i*7 +: 7] = 7'd110;
    end
    seed_load = 1'b1;
    seed      = 16'h0035;
    start     = 1'b1;
    tick(1);
    seed_load = 1'b0;
    start     = 1'b0;
    tick(2);
    chk("midrst_busy_pre", 32'(busy), 32'd1);
    chk("midrst_valid_pre", 32'(valid), 32'd0);
    #3 reset = 1'b1;
    #1;
    chk("midrst_x", 32'(apple_x), 32'd30);
    chk("midrst_y", 32'(apple_y), 32'd30);
    chk("midrst_valid", 32'(valid), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    for (int n = 0; n < 1000; n++) begin
      bit ok;
      bit hit;
      int cnt;
      cnt = (n % 8 == 7) ? int'($urandom_range(0, 7)) : 4;
      seg_count = 3'(cnt);
      for (int i = 0; i < 4; i++) begin
        seg_x[i*8 +: 8] = 8'($urandom_range(0, 15) * 10);
        seg_y[i*7 +: 7] = 7'($urandom_range(0, 11) * 10);
      end
      seed_load = ($urandom_range(0, 3) == 0);
      seed      = 16'($urandom);
      start     = 1'b1;
      tick(1);
      seed_load = 1'b0;
      start     = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        if (done) begin
          ok = 1'b1;
          break;
        end
        tick(1);
      end
      chk("rnd_done", 32'(ok), 32'd1);
      if (!ok) break;
      if (cnt > 4) cnt = 4;
      hit = 1'b0;
      for (int i = 0; i < cnt; i++)
        if (seg_x[i*8 +: 8] == apple_x && seg_y[i*7 +: 7] == apple_y) hit = 1'b1;
      chk("rnd_hit", 32'(hit), 32'd0);
      chk("rnd_xmod", 32'(apple_x) % 10, 32'd0);
      chk("rnd_ymod", 32'(apple_y) % 10, 32'd0);
      chk("rnd_xrange", 32'(apple_x <= 8'd150), 32'd1);
      chk("rnd_yrange", 32'(apple_y <= 7'd110), 32'd1);
      chk("rnd_valid", 32'(valid), 32'd1);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
